// File: rtl/mux_scan_if.sv
// Channel-mux scan bus: start/mask request, mux select/return and snapshot handshake.
// master = scan controller, slave = requester/downstream/mux side.
interface mux_scan_if;
    logic        start;
    logic [15:0] chan_mask;
    logic [3:0]  sel;
    logic        mux_out;
    logic [15:0] snap_data;
    logic        snap_valid;
    logic        snap_ready;
    logic        busy;

    modport master (
        input  start, chan_mask, mux_out, snap_ready,
        output sel, snap_data, snap_valid, busy
    );

    modport slave (
        output start, chan_mask, mux_out, snap_ready,
        input  sel, snap_data, snap_valid, busy
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for the 16:1 single-bit channel mux: steps the select over the enabled
// channels, waits a settle time on each, samples, and hands out a 16-bit snapshot.
//
// state | meaning
// IDLE  | waiting for start; sel holds its last value
// SCAN  | settling/sampling enabled channels in ascending order
// HOLD  | snapshot valid, waiting for snap_ready
module mux_scan_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    mux_scan_if.master  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);

    state_t           state;
    logic [3:0]       sel_q;
    logic [15:0]      snap_data_q;
    logic             snap_valid_q;
    logic             busy_q;
    logic [15:0]      mask_q;
    logic [15:0]      capture;
    logic [CNT_W-1:0] cnt;

    logic [15:0]      above_sel;
    logic             has_next;
    logic [15:0]      capture_next;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Channels strictly above the current select that are still to be visited.
    always_comb begin
        above_sel           = mask_q & (16'hFFFE << sel_q);
        has_next            = |above_sel;
        capture_next        = capture;
        capture_next[sel_q] = bus.mux_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sel_q        <= 4'd0;
            snap_data_q  <= 16'd0;
            snap_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            mask_q       <= 16'd0;
            capture      <= 16'd0;
            cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mask_q  <= bus.chan_mask;
                        capture <= 16'd0;
                        busy_q  <= 1'b1;
                        if (bus.chan_mask != 16'd0) begin
                            sel_q <= lowest_set(bus.chan_mask);
                            cnt   <= SETTLE_INIT;
                            state <= SCAN;
                        end else begin
                            snap_data_q  <= 16'd0;
                            snap_valid_q <= 1'b1;
                            state        <= HOLD;
                        end
                    end
                end
                SCAN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        capture <= capture_next;
                        if (has_next) begin
                            sel_q <= lowest_set(above_sel);
                            cnt   <= SETTLE_INIT;
                        end else begin
                            snap_data_q  <= capture_next;
                            snap_valid_q <= 1'b1;
                            state        <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.snap_ready) begin
                        snap_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    snap_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel        = sel_q;
    assign bus.snap_data  = snap_data_q;
    assign bus.snap_valid = snap_valid_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: queue-based scan model checked every cycle, plus
// directed scans with hand-computed snapshots and latencies.
module tb_mux_scan_ctrl;
    localparam int S = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] pattern = 16'h0000;
    int n_pass  = 0;
    int n_total = 0;
    bit done    = 1'b0;
    int lat;

    mux_scan_if bus ();

    mux_scan_ctrl #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.mux_out = pattern[bus.sel];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Model: on accept, the whole select timeline is laid out as a queue
    // (each enabled channel repeated S+1 times); one entry per edge.
    int          m_mode  = 0;   // 0 idle, 1 scanning, 2 holding
    logic [3:0]  m_sel   = 4'd0;
    logic [15:0] m_data  = 16'd0;
    logic [15:0] m_final = 16'd0;
    logic        m_valid = 1'b0;
    int          m_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_sel = 4'd0; m_data = 16'd0; m_valid = 1'b0; m_q.delete();
        end else begin
            case (m_mode)
                0: if (bus.start) begin
                    if (bus.chan_mask == 16'd0) begin
                        m_data = 16'd0; m_valid = 1'b1; m_mode = 2;
                    end else begin
                        m_q.delete();
                        for (int ch = 0; ch < 16; ch++)
                            if (bus.chan_mask[ch])
                                for (int r = 0; r <= S; r++) m_q.push_back(ch);
                        m_final = pattern & bus.chan_mask;
                        m_sel   = 4'(m_q.pop_front());
                        m_mode  = 1;
                    end
                end
                1: if (m_q.size() == 0) begin
                    m_data = m_final; m_valid = 1'b1; m_mode = 2;
                end else begin
                    m_sel = 4'(m_q.pop_front());
                end
                default: if (bus.snap_ready) begin
                    m_valid = 1'b0; m_mode = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            chk("sel", 32'(bus.sel), 32'(m_sel));
            chk("busy", 32'(bus.busy), 32'(m_mode != 0));
            chk("snap_valid", 32'(bus.snap_valid), 32'(m_valid));
            if (m_valid) chk("snap_data", 32'(bus.snap_data), 32'(m_data));
        end
    end

    task automatic begin_scan(input logic [15:0] m, input logic [15:0] p);
        @(negedge clk);
        pattern = p; bus.chan_mask = m; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(output int l);
        l = 0;
        while (!bus.snap_valid && l < 300) begin
            @(posedge clk); #1; l++;
        end
        if (!bus.snap_valid) chk("valid_timeout", 32'(bus.snap_valid), 32'd1);
    endtask

    task automatic consume();
        @(negedge clk); bus.snap_ready = 1'b1;
        @(posedge clk); #1;
        chk("valid_drop", 32'(bus.snap_valid), 32'd0);
        bus.snap_ready = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.chan_mask = 16'd0; bus.snap_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_valid", 32'(bus.snap_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_data", 32'(bus.snap_data), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // full scan
        begin_scan(16'hFFFF, 16'hA5C3);
        chk("full_busy", 32'(bus.busy), 32'd1);
        wait_valid(lat);
        chk("full_latency", 32'(lat), 32'd32);
        chk("full_data", 32'(bus.snap_data), 32'hA5C3);
        chk("full_last_sel", 32'(bus.sel), 32'd15);
        consume();

        // sparse mask
        begin_scan(16'h8101, 16'hFFFF);
        chk("sparse_first_sel", 32'(bus.sel), 32'd0);
        wait_valid(lat);
        chk("sparse_latency", 32'(lat), 32'd6);
        chk("sparse_data", 32'(bus.snap_data), 32'h8101);
        consume();

        // backpressure, start ignored in HOLD
        begin_scan(16'h000F, 16'h0005);
        wait_valid(lat);
        chk("bp_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin bus.start = 1'b1; bus.chan_mask = 16'hFFFF; end
            if (i == 4) bus.start = 1'b0;
        end
        #1;
        chk("bp_data_stable", 32'(bus.snap_data), 32'h0005);
        chk("bp_still_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.snap_ready = 1'b1; bus.start = 1'b1; bus.chan_mask = 16'h0002; pattern = 16'h0002;
        @(posedge clk); #1;
        chk("bp_valid_drop", 32'(bus.snap_valid), 32'd0);
        chk("bp_idle_gap", 32'(bus.busy), 32'd0);
        bus.snap_ready = 1'b0;
        @(posedge clk); #1;
        chk("bp_restart_accept", 32'(bus.busy), 32'd1);
        chk("bp_restart_sel", 32'(bus.sel), 32'd1);
        bus.start = 1'b0;
        wait_valid(lat);
        chk("bp_restart_data", 32'(bus.snap_data), 32'h0002);
        consume();

        // mask change mid-scan
        begin_scan(16'h00F0, 16'hFFFF);
        bus.chan_mask = 16'hFFFF;
        wait_valid(lat);
        chk("mchg_latency", 32'(lat), 32'd8);
        chk("mchg_data", 32'(bus.snap_data), 32'h00F0);
        consume();

        // empty mask: valid in the cycle right after the accept edge, sel untouched
        begin_scan(16'h0000, 16'hFFFF);
        chk("empty_valid_one_cycle", 32'(bus.snap_valid), 32'd1);
        chk("empty_data", 32'(bus.snap_data), 32'd0);
        chk("empty_sel_held", 32'(bus.sel), 32'd7);
        consume();

        // asynchronous reset mid-scan
        begin_scan(16'hFFFF, 16'hA5C3);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_sel", 32'(bus.sel), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel", 32'(bus.sel), 32'd0);
        chk("async_rst_valid", 32'(bus.snap_valid), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        begin_scan(16'h0001, 16'h0001);
        wait_valid(lat);
        chk("post_rst_latency", 32'(lat), 32'd2);
        chk("post_rst_data", 32'(bus.snap_data), 32'h0001);
        consume();

        repeat (2) @(posedge clk);
        done = 1'b1;
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
